// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/forwarding scoreboard: writer slots, forwarding
// select encoding, multi-cycle FSM states and small match helpers.
package hazard_scoreboard_pkg;

    // Slot rd storage width; the top zero-extends REG_ADDR_W indices into it.
    localparam int SLOT_RD_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
        logic                 is_load;
    } hz_slot_s;

    // Older stages only need the destination, not the load flag.
    typedef struct packed {
        logic                 valid;
        logic [SLOT_RD_W-1:0] rd;
    } hz_dst_s;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_XM = 2'b10,
        FWD_MW = 2'b01,
        FWD_WB = 2'b11
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    function automatic logic slot_match(input hz_dst_s s, input logic [SLOT_RD_W-1:0] rs);
        return s.valid && (s.rd == rs);
    endfunction

    // A writer currently in DX will sit in XM when the consumer is in DX, and so on.
    function automatic fwd_sel_e fwd_pick(input logic m_dx, input logic m_xm, input logic m_mw);
        if (m_dx)      return FWD_XM;
        else if (m_xm) return FWD_MW;
        else if (m_mw) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mc_ctrl.sv
// Multi-cycle op sequencer: holds DX for MC_LAT-1 cycles after a multi-cycle
// op enters, abortable by flush.
module hazard_mc_ctrl
    import hazard_scoreboard_pkg::*;
#(
    parameter int MC_LAT = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic flush,
    input  logic mc_start,
    output logic hold_dx,
    output logic mc_busy
);

    localparam int CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

    mc_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= MC_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            MC_IDLE: begin
                if (mc_start && (MC_LAT > 1)) begin
                    state_next = MC_BUSY;
                    cnt_next   = CNT_W'(MC_LAT - 2);
                end
            end
            MC_BUSY: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
                else               state_next = MC_IDLE;
            end
            default: state_next = MC_IDLE;
        endcase
        // Flush aborts the op even mid-count.
        if (flush) begin
            state_next = MC_IDLE;
            cnt_next   = '0;
        end
    end

    assign mc_busy = (state_reg == MC_BUSY);
    assign hold_dx = mc_busy && !flush;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: mirrors DX/XM/MW writers, registers DX operand
// forwarding selects, detects load-use and sequences multi-cycle ops.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MC_LAT      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [REG_ADDR_W-1:0]  id_rs_a,
    input  logic [REG_ADDR_W-1:0]  id_rs_b,
    input  logic                   id_uses_a,
    input  logic                   id_uses_b,
    input  logic [REG_ADDR_W-1:0]  id_rd,
    input  logic                   id_writes_rf,
    input  logic                   id_is_load,
    input  logic                   id_is_mc,
    output logic                   stall_id,
    output logic                   bubble_dx,
    output logic                   hold_dx,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   mc_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    hz_slot_s dx_reg;
    hz_dst_s  xm_reg, mw_reg, dx_dst;
    hz_slot_s id_slot;

    logic [1:0][REG_ADDR_W-1:0] rs_src;
    logic [1:0]                 use_src;
    logic [1:0]                 match_dx, match_xm, match_mw;
    logic [3:0]                 fwd_next, fwd_reg;
    logic                       load_use, mc_start;
    logic [STALL_CNT_W-1:0]     stall_cnt_reg;

    assign rs_src  = {id_rs_b, id_rs_a};
    assign use_src = {id_uses_b, id_uses_a};
    assign dx_dst  = '{valid: dx_reg.valid, rd: dx_reg.rd};

    assign id_slot.valid   = id_valid && id_writes_rf && (id_rd != '0);
    assign id_slot.rd      = SLOT_RD_W'(id_rd);
    assign id_slot.is_load = id_is_load;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        logic                 live;
        logic [SLOT_RD_W-1:0] rs_ext;
        assign rs_ext       = SLOT_RD_W'(rs_src[gi]);
        assign live         = id_valid && use_src[gi] && (rs_src[gi] != '0);
        assign match_dx[gi] = live && slot_match(dx_dst, rs_ext);
        assign match_xm[gi] = live && slot_match(xm_reg, rs_ext);
        assign match_mw[gi] = live && slot_match(mw_reg, rs_ext);
        // Anything that does not admit a fresh instruction into DX selects RF.
        assign fwd_next[gi*2 +: 2] = (flush || stall_id) ? FWD_RF
                                   : fwd_pick(match_dx[gi], match_xm[gi], match_mw[gi]);
    end

    assign load_use  = (|match_dx) && dx_reg.is_load;
    assign stall_id  = !flush && (hold_dx || load_use);
    assign bubble_dx = flush || (load_use && !hold_dx);
    assign mc_start  = id_valid && id_is_mc && !stall_id && !flush;

    hazard_mc_ctrl #(.MC_LAT(MC_LAT)) u_mc_ctrl (
        .clk      (clk),
        .n_reset  (n_reset),
        .flush    (flush),
        .mc_start (mc_start),
        .hold_dx  (hold_dx),
        .mc_busy  (mc_busy)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            dx_reg        <= '0;
            xm_reg        <= '0;
            mw_reg        <= '0;
            fwd_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            if (flush)         dx_reg <= '0;
            else if (hold_dx)  dx_reg <= dx_reg;
            else if (stall_id) dx_reg <= '0;
            else               dx_reg <= id_slot;
            // The DX occupant is wrong-path on flush and never reaches XM.
            xm_reg  <= (hold_dx || flush) ? '0 : dx_dst;
            mw_reg  <= xm_reg;
            fwd_reg <= fwd_next;
            if (stall_id && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
        end
    end

    assign fwd_a       = fwd_reg[1:0];
    assign fwd_b       = fwd_reg[3:2];
    assign stall_count = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MC_LAT=4, STALL_CNT_W=4): forwarding
// distances, load-use, multi-cycle hold, flush abort, reset and counter saturation.
module tb_hazard_scoreboard;

    logic       clk;
    logic       n_reset;
    logic       flush;
    logic       id_valid;
    logic [4:0] id_rs_a, id_rs_b, id_rd;
    logic       id_uses_a, id_uses_b, id_writes_rf, id_is_load, id_is_mc;
    logic       stall_id, bubble_dx, hold_dx, mc_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_count;

    int vectors;
    int miscompares;

    hazard_scoreboard #(.REG_ADDR_W(5), .MC_LAT(4), .STALL_CNT_W(4)) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_rs_a      (id_rs_a),
        .id_rs_b      (id_rs_b),
        .id_uses_a    (id_uses_a),
        .id_uses_b    (id_uses_b),
        .id_rd        (id_rd),
        .id_writes_rf (id_writes_rf),
        .id_is_load   (id_is_load),
        .id_is_mc     (id_is_mc),
        .stall_id     (stall_id),
        .bubble_dx    (bubble_dx),
        .hold_dx      (hold_dx),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mc_busy      (mc_busy),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [4:0] ra, input logic ua,
                          input logic [4:0] rb, input logic ub, input logic [4:0] rd,
                          input logic wr, input logic ld, input logic mc);
        id_valid = v; id_rs_a = ra; id_uses_a = ua; id_rs_b = rb; id_uses_b = ub;
        id_rd = rd; id_writes_rf = wr; id_is_load = ld; id_is_mc = mc;
    endtask

    task automatic nop();
        id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (4) tick();
    endtask

    // Producer of r3, then a consumer reading r3 on both operands 'gap' cycles later.
    task automatic run_dist(input int gap, input logic [1:0] exp, input string tag);
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < gap; i++) begin
            nop();
            tick();
        end
        id_set(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        #1 chk({tag, "_stall"}, 16'(stall_id), 16'd0);
        tick();
        chk({tag, "_fwd_a"}, 16'(fwd_a), 16'(exp));
        chk({tag, "_fwd_b"}, 16'(fwd_b), 16'(exp));
        drain();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        n_reset = 1'b0;
        flush = 1'b0;
        nop();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 16'(stall_id), 16'd0);
        chk("rst_bubble", 16'(bubble_dx), 16'd0);
        chk("rst_hold", 16'(hold_dx), 16'd0);
        chk("rst_fwd_a", 16'(fwd_a), 16'd0);
        chk("rst_fwd_b", 16'(fwd_b), 16'd0);
        chk("rst_busy", 16'(mc_busy), 16'd0);
        chk("rst_cnt", 16'(stall_count), 16'd0);
        n_reset = 1'b1;
        tick();

        // Forwarding distance 1..4
        run_dist(1, 2'b10, "dist1");
        run_dist(2, 2'b01, "dist2");
        run_dist(3, 2'b11, "dist3");
        run_dist(4, 2'b00, "dist4");

        // Youngest writer wins; operands select independently
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
        id_set(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0); tick();
        chk("young_fwd_a", 16'(fwd_a), 16'b10);
        drain();
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0); tick();
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
        id_set(1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); tick();
        chk("mix_fwd_a", 16'(fwd_a), 16'b10);
        chk("mix_fwd_b", 16'(fwd_b), 16'b01);
        drain();

        // Load-use on operand A
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
        id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 16'(stall_id), 16'd1);
        chk("lu_bubble", 16'(bubble_dx), 16'd1);
        tick();
        chk("lu_bub_fwd", 16'(fwd_a), 16'b00);
        #1;
        chk("lu_stall2", 16'(stall_id), 16'd0);
        chk("lu_bubble2", 16'(bubble_dx), 16'd0);
        tick();
        chk("lu_fwd_a", 16'(fwd_a), 16'b01);
        drain();

        // Load-use on operand B, then B register present but not read
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
        id_set(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("lub_stall", 16'(stall_id), 16'd1);
        tick();
        drain();
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
        id_set(1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        #1 chk("lub_unused", 16'(stall_id), 16'd0);
        tick();
        drain();
        chk("cnt_after_lu", 16'(stall_count), 16'd2);

        // Multi-cycle op with dependent add
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
        #1 chk("mc_entry_stall", 16'(stall_id), 16'd0);
        tick();
        id_set(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mc_hold", 16'(hold_dx), 16'd1);
            chk("mc_stall", 16'(stall_id), 16'd1);
            chk("mc_busy", 16'(mc_busy), 16'd1);
            chk("mc_bubble", 16'(bubble_dx), 16'd0);
            tick();
            chk("mc_held_fwd", 16'(fwd_a), 16'b00);
        end
        #1;
        chk("mc_done_hold", 16'(hold_dx), 16'd0);
        chk("mc_done_stall", 16'(stall_id), 16'd0);
        chk("mc_done_busy", 16'(mc_busy), 16'd0);
        tick();
        chk("mc_dep_fwd", 16'(fwd_a), 16'b10);
        drain();
        chk("cnt_after_mc", 16'(stall_count), 16'd5);

        // r0 and non-writing producers never forward
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
        id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0_stall", 16'(stall_id), 16'd0);
        chk("r0_bubble", 16'(bubble_dx), 16'd0);
        tick();
        chk("r0_fwd", 16'(fwd_a), 16'b00);
        drain();
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0); tick();
        id_set(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0); tick();
        chk("nowr_fwd", 16'(fwd_a), 16'b00);
        drain();

        // Flush while MC_BUSY with one count left
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1); tick();
        nop();
        #1 chk("fl_busy_pre", 16'(mc_busy), 16'd1);
        tick();
        flush = 1'b1;
        id_set(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("fl_stall", 16'(stall_id), 16'd0);
        chk("fl_hold", 16'(hold_dx), 16'd0);
        chk("fl_bubble", 16'(bubble_dx), 16'd1);
        tick();
        flush = 1'b0;
        chk("fl_busy_post", 16'(mc_busy), 16'd0);
        chk("fl_hold_post", 16'(hold_dx), 16'd0);
        chk("fl_fwd_a", 16'(fwd_a), 16'b00);
        chk("fl_fwd_b", 16'(fwd_b), 16'b00);
        #1 chk("fl_stall_post", 16'(stall_id), 16'd0);
        tick();
        chk("fl_busy_stays", 16'(mc_busy), 16'd0);
        drain();
        chk("cnt_after_fl", 16'(stall_count), 16'd6);

        // Reset asserted mid-MC
        id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1); tick();
        nop();
        #1 chk("rmc_busy_pre", 16'(mc_busy), 16'd1);
        n_reset = 1'b0;
        #1;
        chk("rmc_busy", 16'(mc_busy), 16'd0);
        chk("rmc_hold", 16'(hold_dx), 16'd0);
        chk("rmc_cnt", 16'(stall_count), 16'd0);
        tick();
        n_reset = 1'b1;
        tick();

        // Saturating stall counter
        for (int i = 0; i < 20; i++) begin
            id_set(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); tick();
            id_set(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0); tick();
            nop(); tick();
            if (i == 9) chk("sat_cnt10", 16'(stall_count), 16'd10);
        end
        chk("sat_cnt", 16'(stall_count), 16'd15);
        n_reset = 1'b0;
        #1 chk("sat_rst", 16'(stall_count), 16'd0);
        tick();
        n_reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
